// File: rtl/spi_sat_arbiter.sv
// spi_sat_arbiter: round-robin front end that shares one spi_sat transfer
// engine between NUM_REQ command requesters. One transfer is in flight at a
// time; the captured response is returned tagged with the winning requester.
// Optional feature: define SPI_SAT_ARB_TIMEOUT_EN to build a WAIT-state
// watchdog (TIMEOUT_CYC cycles) that aborts the core and returns rsp_err.
module spi_sat_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TX_LEN      = 1,
    parameter int RX_LEN      = 1,
    parameter int CS_NUM      = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_REQ-1:0]                            req_valid,
    output logic [NUM_REQ-1:0]                            req_ready,
    input  logic [NUM_REQ*TX_LEN*8-1:0]                   req_cmd,
    input  logic [NUM_REQ*$clog2(CS_NUM>1?CS_NUM:2)-1:0]  req_cs,
    output logic                                          rsp_valid,
    input  logic                                          rsp_ready,
    output logic [RX_LEN*8-1:0]                           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]                    rsp_id,
    output logic                                          rsp_err,
    output logic [TX_LEN*8-1:0]                           core_cmd,
    output logic                                          core_trmt,
    output logic [$clog2(CS_NUM>1?CS_NUM:2)-1:0]          core_cs_idx,
    input  logic [RX_LEN*8-1:0]                           core_resp,
    input  logic                                          core_rx_rdy,
    output logic                                          core_clr_rdy,
    output logic                                          core_abort,
    output logic                                          busy
);

    localparam int CSW = $clog2(CS_NUM > 1 ? CS_NUM : 2);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = TX_LEN * 8;
    localparam int RW  = RX_LEN * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   win_r;
    logic [IDW-1:0]   win_s;
    logic             found_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [CW-1:0]    core_cmd_r;
    logic [CSW-1:0]   core_cs_r;
    logic [RW-1:0]    rsp_data_r;
    logic             core_trmt_r;
    logic             rsp_valid_r;
    logic             busy_r;
    logic             timeout_s;

`ifdef SPI_SAT_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0]   cnt_r;
    logic             rsp_err_r;
    logic             core_abort_r;

    // Watchdog expires in the last allowed WAIT cycle unless the core answers.
    assign timeout_s = (state_r == ST_WAIT) && !core_rx_rdy &&
                       (cnt_r == TCW'(TIMEOUT_CYC - 1));

    // WAIT-state cycle counter, restarted whenever a transfer is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_next_s == ST_ISSUE) begin
            cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + TCW'(1'b1);
        end
    end

    // Error flag and one-cycle abort pulse raised on watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_r    <= 1'b0;
            core_abort_r <= 1'b0;
        end else begin
            core_abort_r <= timeout_s;
            if (state_r == ST_WAIT && core_rx_rdy) begin
                rsp_err_r <= 1'b0;
            end else if (timeout_s) begin
                rsp_err_r <= 1'b1;
            end
        end
    end

    assign rsp_err    = rsp_err_r;
    assign core_abort = core_abort_r;
`else
    assign timeout_s  = 1'b0;
    assign rsp_err    = 1'b0;
    assign core_abort = 1'b0;
`endif

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        int idx_v;
        found_s = 1'b0;
        win_s   = '0;
        idx_v   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = (int'(ptr_r) + i) % NUM_REQ;
            if (!found_s && req_valid[idx_v]) begin
                found_s = 1'b1;
                win_s   = IDW'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the IDLE/ISSUE/WAIT/RESP transfer sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) state_next_s = ST_ISSUE;
                else         state_next_s = ST_IDLE;
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (core_rx_rdy || timeout_s) state_next_s = ST_RESP;
                else                          state_next_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready) state_next_s = ST_IDLE;
                else           state_next_s = ST_RESP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // One-hot accept, only in IDLE and only for the winning requester.
    always_comb begin
        req_ready_s = '0;
        if (state_r == ST_IDLE && found_s) req_ready_s[win_s] = 1'b1;
        else                               req_ready_s = '0;
    end

    // State register and state-decoded strobes, registered for clean outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            core_trmt_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            core_trmt_r <= (state_next_s == ST_ISSUE);
            rsp_valid_r <= (state_next_s == ST_RESP);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Grant-time capture of the winner's command, chip select and ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r      <= '0;
            core_cmd_r <= '0;
            core_cs_r  <= '0;
        end else if (state_r == ST_IDLE && found_s) begin
            win_r      <= win_s;
            core_cmd_r <= req_cmd[win_s*CW +: CW];
            core_cs_r  <= req_cs[win_s*CSW +: CSW];
        end
    end

    // Response capture; a timed-out transfer returns all-zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r <= '0;
        end else if (state_r == ST_WAIT && core_rx_rdy) begin
            rsp_data_r <= core_resp;
        end else if (timeout_s) begin
            rsp_data_r <= '0;
        end
    end

    // Pointer moves past the winner once its response is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (state_r == ST_RESP && rsp_ready) begin
            ptr_r <= (win_r == IDW'(NUM_REQ - 1)) ? '0 : win_r + IDW'(1'b1);
        end
    end

    // Completion (or a spurious rx_rdy outside WAIT) is acknowledged at once.
    assign core_clr_rdy = core_rx_rdy;
    assign req_ready    = req_ready_s;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_id       = win_r;
    assign core_cmd     = core_cmd_r;
    assign core_trmt    = core_trmt_r;
    assign core_cs_idx  = core_cs_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_spi_sat_arbiter.sv
// Directed testbench for spi_sat_arbiter (NUM_REQ=4, CS_NUM=2, TIMEOUT_CYC=16).
// The watchdog scenarios run only when SPI_SAT_ARB_TIMEOUT_EN is defined;
// otherwise a long WAIT must produce neither abort nor error.
module tb_spi_sat_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [31:0] req_cmd;
    logic [3:0] req_cs;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_id;
    logic       rsp_err;
    logic [7:0] core_cmd;
    logic       core_trmt;
    logic       core_cs_idx;
    logic [7:0] core_resp;
    logic       core_rx_rdy;
    logic       core_clr_rdy;
    logic       core_abort;
    logic       busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [7:0] cmd_tab [4] = '{8'h11, 8'hA5, 8'h33, 8'h44};
    logic       cs_tab  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    spi_sat_arbiter #(
        .NUM_REQ(4), .TX_LEN(1), .RX_LEN(1), .CS_NUM(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_cs(req_cs),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .core_cmd(core_cmd), .core_trmt(core_trmt), .core_cs_idx(core_cs_idx),
        .core_resp(core_resp), .core_rx_rdy(core_rx_rdy),
        .core_clr_rdy(core_clr_rdy), .core_abort(core_abort), .busy(busy)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Full transfer: grant, issue, wait_cyc idle WAIT cycles, completion,
    // bp_cyc cycles of held-off response; returns in the handshake cycle.
    task automatic run_txn(input logic [3:0] vmask, input logic hold, input int exp_id,
                           input logic [7:0] resp, input int wait_cyc, input int bp_cyc);
        @(negedge clk); req_valid = vmask; #1;
        check_val("grant", 32'(req_ready), 32'd1 << exp_id);
        check_val("idle_busy", 32'(busy), 32'd0);
        @(negedge clk); if (!hold) req_valid = 4'b0000; #1;
        check_val("trmt", 32'(core_trmt), 32'd1);
        check_val("cmd", 32'(core_cmd), 32'(cmd_tab[exp_id]));
        check_val("cs_issue", 32'(core_cs_idx), 32'(cs_tab[exp_id]));
        check_val("no_ready_issue", 32'(req_ready), 32'd0);
        check_val("busy", 32'(busy), 32'd1);
        for (int k = 0; k < wait_cyc; k++) begin
            @(negedge clk); #1;
            check_val("trmt_once", 32'(core_trmt), 32'd0);
            check_val("wait_no_rsp", 32'(rsp_valid), 32'd0);
            check_val("wait_no_abort", 32'(core_abort), 32'd0);
            check_val("cs_wait", 32'(core_cs_idx), 32'(cs_tab[exp_id]));
        end
        @(negedge clk); core_rx_rdy = 1'b1; core_resp = resp;
        if (bp_cyc > 0) rsp_ready = 1'b0;
        #1;
        check_val("clr_rdy", 32'(core_clr_rdy), 32'd1);
        check_val("rsp_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk); core_rx_rdy = 1'b0; core_resp = 8'hFF; #1;
        check_val("rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("rsp_data", 32'(rsp_data), 32'(resp));
        check_val("rsp_id", 32'(rsp_id), 32'(exp_id));
        check_val("rsp_err", 32'(rsp_err), 32'd0);
        check_val("cs_resp", 32'(core_cs_idx), 32'(cs_tab[exp_id]));
        check_val("no_ready_resp", 32'(req_ready), 32'd0);
        for (int k = 0; k < bp_cyc; k++) begin
            @(negedge clk); #1;
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_data", 32'(rsp_data), 32'(resp));
            check_val("bp_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
    endtask

    // Directed scenario sequence.
    initial begin
        rst_n       = 1'b0;
        req_valid   = 4'b0000;
        req_cmd     = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        req_cs      = {cs_tab[3], cs_tab[2], cs_tab[1], cs_tab[0]};
        rsp_ready   = 1'b1;
        core_resp   = 8'h00;
        core_rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_trmt", 32'(core_trmt), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_data", 32'(rsp_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Round robin with all requesters held: 0,1,2,3 then 0 again.
        run_txn(4'b1111, 1'b1, 0, 8'hC0, 2, 0);
        run_txn(4'b1111, 1'b1, 1, 8'hC1, 0, 0);
        run_txn(4'b1111, 1'b1, 2, 8'hC2, 1, 0);
        run_txn(4'b1111, 1'b1, 3, 8'hC3, 3, 0);
        run_txn(4'b1111, 1'b0, 0, 8'hC4, 0, 0);

        // Single request from requester 1 (ptr now 1).
        run_txn(4'b0010, 1'b0, 1, 8'h3C, 2, 0);

        // Backpressure with requester 0 pending, then grant right after handshake.
        run_txn(4'b0001, 1'b1, 0, 8'h96, 1, 20);
        run_txn(4'b0001, 1'b0, 0, 8'h69, 0, 0);

        // Chip-select steering: requester 2 uses cs 1.
        run_txn(4'b0100, 1'b0, 2, 8'h5E, 3, 0);

        // Spurious completion while idle is cleared and ignored.
        @(negedge clk); core_rx_rdy = 1'b1; #1;
        check_val("spur_clr", 32'(core_clr_rdy), 32'd1);
        check_val("spur_busy", 32'(busy), 32'd0);
        @(negedge clk); core_rx_rdy = 1'b0; #1;
        check_val("spur_no_rsp", 32'(rsp_valid), 32'd0);
        check_val("spur_idle", 32'(busy), 32'd0);

        // Reset during WAIT (ptr is 3, so 4'b0100 wins as requester 2).
        @(negedge clk); req_valid = 4'b0100; #1;
        check_val("pre_rst_grant", 32'(req_ready), 32'd4);
        @(negedge clk); req_valid = 4'b0000; #1;
        check_val("pre_rst_trmt", 32'(core_trmt), 32'd1);
        @(negedge clk); #1;
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk); rst_n = 1'b0; #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_cmd", 32'(core_cmd), 32'd0);
        check_val("mid_rst_cs", 32'(core_cs_idx), 32'd0);
        check_val("mid_rst_id", 32'(rsp_id), 32'd0);
        check_val("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_val("mid_rst_abort", 32'(core_abort), 32'd0);
        check_val("mid_rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        check_val("post_rst_valid", 32'(rsp_valid), 32'd0);
        // ptr back at 0: requester 0 first, then requester 3.
        run_txn(4'b1001, 1'b1, 0, 8'h81, 0, 0);
        run_txn(4'b1001, 1'b0, 3, 8'h83, 1, 0);

`ifdef SPI_SAT_ARB_TIMEOUT_EN
        // Core never answers: abort after 16 WAIT cycles, error response.
        @(negedge clk); req_valid = 4'b0001; #1;
        check_val("to_grant", 32'(req_ready), 32'd1);
        @(negedge clk); req_valid = 4'b0000; #1;
        check_val("to_trmt", 32'(core_trmt), 32'd1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            check_val("to_no_abort", 32'(core_abort), 32'd0);
            check_val("to_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk); #1;
        check_val("to_abort", 32'(core_abort), 32'd1);
        check_val("to_valid", 32'(rsp_valid), 32'd1);
        check_val("to_err", 32'(rsp_err), 32'd1);
        check_val("to_data", 32'(rsp_data), 32'd0);
        @(negedge clk); #1;
        check_val("to_abort_once", 32'(core_abort), 32'd0);
        check_val("to_idle", 32'(busy), 32'd0);
        // rx_rdy in the 16th WAIT cycle beats the watchdog.
        run_txn(4'b0010, 1'b0, 1, 8'h5A, 15, 0);
`else
        // Without the watchdog a long WAIT never aborts.
        run_txn(4'b0001, 1'b0, 0, 8'h77, 40, 0);
`endif

        @(negedge clk); #1;
        check_val("final_idle", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
